countdown_timer_bcd: RTL

Downstream consumer of the 100 ms LFSR timer. Converts its single-cycle 100 ms timeout pulses into a loadable two-digit BCD seconds countdown with a tenths digit. Drives the upstream timer's enable from its own run state. Flags expiry of the pattern-entry time limit to the game controller.

---
 rtl/countdown_timer_bcd.sv | 104 ++++++++++
 1 files changed

// File: rtl/countdown_timer_bcd.sv
// countdown_timer_bcd: loadable BCD seconds.tenths countdown paced by 100 ms ticks
module countdown_timer_bcd #(
    parameter logic [3:0] TENTHS_RELOAD = 4'd9,
    parameter bit         CLAMP_BCD     = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
    input  logic       start,
    input  logic       pause,
    input  logic       tick_100ms,
    output logic       timer_enable,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [3:0] tenths,
    output logic       running,
    output logic       expired,
    output logic       expire_pulse
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;
    state_t state;
    logic [3:0] ld_tens, ld_ones, dec_tens, dec_ones, dec_tenths;
    logic       nonzero, dec_zero;
    // Clamp load digits and form the next count one tick below the current one
    always_comb begin
        ld_tens    = (CLAMP_BCD && load_tens > 4'd9) ? 4'd9 : load_tens;
        ld_ones    = (CLAMP_BCD && load_ones > 4'd9) ? 4'd9 : load_ones;
        nonzero    = |{sec_tens, sec_ones, tenths};
        dec_tenths = (tenths != 4'd0) ? tenths - 4'd1 : (nonzero ? TENTHS_RELOAD : 4'd0);
        dec_ones   = (tenths != 4'd0) ? sec_ones : (sec_ones != 4'd0) ? sec_ones - 4'd1 : (sec_tens != 4'd0) ? 4'd9 : 4'd0;
        dec_tens   = (tenths != 4'd0 || sec_ones != 4'd0 || sec_tens == 4'd0) ? sec_tens : sec_tens - 4'd1;
        dec_zero   = ~|{dec_tens, dec_ones, dec_tenths};
    end
    // Control FSM with registered digits and status outputs
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state        <= IDLE;
            sec_tens     <= 4'd0;
            sec_ones     <= 4'd0;
            tenths       <= 4'd0;
            timer_enable <= 1'b0;
            running      <= 1'b0;
            expired      <= 1'b0;
            expire_pulse <= 1'b0;
        end else begin
            expire_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        sec_tens <= ld_tens;
                        sec_ones <= ld_ones;
                        tenths   <= 4'd0;
                    end else if (start && nonzero) begin
                        state        <= RUN;
                        timer_enable <= 1'b1;
                        running      <= 1'b1;
                    end
                end
                RUN: begin
                    if (tick_100ms) begin
                        sec_tens <= dec_tens;
                        sec_ones <= dec_ones;
                        tenths   <= dec_tenths;
                    end
                    if (tick_100ms && dec_zero) begin
                        state        <= EXPIRED;
                        expired      <= 1'b1;
                        expire_pulse <= 1'b1;
                        timer_enable <= 1'b0;
                        running      <= 1'b0;
                    end else if (pause) begin
                        state        <= PAUSE;
                        timer_enable <= 1'b0;
                        running      <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (load) begin
                        state    <= IDLE;
                        sec_tens <= ld_tens;
                        sec_ones <= ld_ones;
                        tenths   <= 4'd0;
                    end else if (start) begin
                        state        <= RUN;
                        timer_enable <= 1'b1;
                        running      <= 1'b1;
                    end
                end
                default: begin
                    if (load) begin
                        state    <= IDLE;
                        expired  <= 1'b0;
                        sec_tens <= ld_tens;
                        sec_ones <= ld_ones;
                        tenths   <= 4'd0;
                    end
                end
            endcase
        end
    end
endmodule
